// File: rtl/qpu_exu_evt_sched_pkg.sv
// Shared widths and FSM encodings for the QPU event scheduler.
package qpu_exu_evt_sched_pkg;

  localparam int QPU_TIME_WIDTH       = 16;
  localparam int QPU_EVENT_WIRE_WIDTH = 8;
  localparam int QPU_EVENT_NUM        = 8;
  localparam int QPU_EVT_SCHED_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/qpu_exu_evt_sched_if.sv
// Write-back handshake bundle between the ALU/QIU ports and the scheduler.
interface qpu_exu_evt_sched_if #(
  parameter int TIME_W  = 16,
  parameter int EDATA_W = 8,
  parameter int OPR_W   = 8
);
  logic               twbck_i_valid;
  logic               twbck_i_ready;
  logic [TIME_W-1:0]  twbck_i_data;
  logic               ewbck_i_valid;
  logic               ewbck_i_ready;
  logic [EDATA_W-1:0] ewbck_i_data;
  logic [OPR_W-1:0]   ewbck_i_oprand;

  modport master (
    output twbck_i_valid, twbck_i_data,
    output ewbck_i_valid, ewbck_i_data, ewbck_i_oprand,
    input  twbck_i_ready, ewbck_i_ready
  );

  modport slave (
    input  twbck_i_valid, twbck_i_data,
    input  ewbck_i_valid, ewbck_i_data, ewbck_i_oprand,
    output twbck_i_ready, ewbck_i_ready
  );
endinterface

// File: rtl/qpu_exu_evt_sched_fifo.sv
// Stamped-event FIFO: extra pointer bit distinguishes full from empty,
// head entry is read combinationally so the release check sees it at once.
module qpu_evt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Pointer advance and full/empty flags from the current pointers.
  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    o_rdata  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointers are control state and are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array carries data only; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/qpu_exu_evt_sched.sv
// Timing-queue scheduler: stamps event write-backs with the program timeline
// and releases them when the free-running system timer reaches the stamp.
module qpu_exu_evt_sched
  import qpu_exu_evt_sched_pkg::*;
#(
  parameter int TIME_W  = QPU_TIME_WIDTH,
  parameter int EDATA_W = QPU_EVENT_WIRE_WIDTH,
  parameter int OPR_W   = QPU_EVENT_NUM,
  parameter int DEPTH   = QPU_EVT_SCHED_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  qpu_exu_evt_sched_if.slave wb,
  output logic               o_evt_valid,
  output logic [EDATA_W-1:0] o_evt_data,
  output logic [OPR_W-1:0]   o_evt_oprand,
  output logic [TIME_W-1:0]  o_evt_time,
  output logic [TIME_W-1:0]  o_sys_time,
  output logic               o_late,
  output logic               o_busy
);
  localparam int ENT_W = TIME_W + EDATA_W + OPR_W;

  sched_state_e       state_q, state_d;
  logic [TIME_W-1:0]  sys_time_q, sys_time_d;
  logic [TIME_W-1:0]  timeline_q, timeline_d;
  logic               late_q, late_d;
  logic               evt_valid_q, evt_valid_d;
  logic [EDATA_W-1:0] evt_data_q, evt_data_d;
  logic [OPR_W-1:0]   evt_oprand_q, evt_oprand_d;
  logic [TIME_W-1:0]  evt_time_q, evt_time_d;

  logic               rdy, t_fire, e_fire, push, pop, late_pop;
  logic [TIME_W-1:0]  next_tl, diff;
  logic [ENT_W-1:0]   head;
  logic [TIME_W-1:0]  head_ts;
  logic [EDATA_W-1:0] head_data;
  logic [OPR_W-1:0]   head_opr;
  logic               fifo_full, fifo_empty;

  qpu_evt_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_wdata ({next_tl, wb.ewbck_i_data, wb.ewbck_i_oprand}),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Accept, stamp and release decisions plus next-state for every register.
  always_comb begin
    // One shared ready keeps a joint time+event beat atomic.
    rdy      = (state_q != ST_DRAIN) && !fifo_full;
    t_fire   = wb.twbck_i_valid && rdy;
    e_fire   = wb.ewbck_i_valid && rdy;
    // Time advance lands before the stamp is taken.
    next_tl  = timeline_q + (t_fire ? wb.twbck_i_data : '0);
    push     = e_fire && (wb.ewbck_i_oprand != '0);

    {head_ts, head_data, head_opr} = head;
    // Modular distance: negative (MSB set) means the stamp is already past.
    diff     = head_ts - sys_time_q;
    pop      = (state_q != ST_IDLE) && !fifo_empty &&
               ((diff == '0) || diff[TIME_W-1]);
    late_pop = pop && diff[TIME_W-1];

    state_d      = state_q;
    sys_time_d   = sys_time_q;
    timeline_d   = next_tl;
    late_d       = late_q || late_pop;
    evt_valid_d  = pop;
    evt_data_d   = pop ? head_data : evt_data_q;
    evt_oprand_d = pop ? head_opr  : evt_oprand_q;
    evt_time_d   = pop ? head_ts   : evt_time_q;

    case (state_q)
      ST_IDLE: begin
        sys_time_d = '0;
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        sys_time_d = sys_time_q + {{(TIME_W-1){1'b0}}, 1'b1};
        if (i_stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d    = ST_IDLE;
          sys_time_d = '0;
          timeline_d = '0;
        end else begin
          sys_time_d = sys_time_q + {{(TIME_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d    = ST_IDLE;
        sys_time_d = '0;
        timeline_d = '0;
      end
    endcase

    wb.twbck_i_ready = rdy;
    wb.ewbck_i_ready = rdy;
    o_evt_valid      = evt_valid_q;
    o_evt_data       = evt_data_q;
    o_evt_oprand     = evt_oprand_q;
    o_evt_time       = evt_time_q;
    o_sys_time       = sys_time_q;
    o_late           = late_q;
    o_busy           = (state_q != ST_IDLE) || !fifo_empty;
  end

  // Scheduler FSM, timers and registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sys_time_q   <= '0;
      timeline_q   <= '0;
      late_q       <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      evt_oprand_q <= '0;
      evt_time_q   <= '0;
    end else begin
      state_q      <= state_d;
      sys_time_q   <= sys_time_d;
      timeline_q   <= timeline_d;
      late_q       <= late_d;
      evt_valid_q  <= evt_valid_d;
      evt_data_q   <= evt_data_d;
      evt_oprand_q <= evt_oprand_d;
      evt_time_q   <= evt_time_d;
    end
  end
endmodule

// File: tb/tb_qpu_exu_evt_sched.sv
// Bench for qpu_exu_evt_sched: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_qpu_exu_evt_sched;
  localparam int TW   = 8;
  localparam int EW   = 8;
  localparam int OW   = 4;
  localparam int DP   = 8;
  localparam int MASK = (1 << TW) - 1;
  localparam int HALF = 1 << (TW - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_stop;
  logic          o_evt_valid, o_late, o_busy;
  logic [EW-1:0] o_evt_data;
  logic [OW-1:0] o_evt_oprand;
  logic [TW-1:0] o_evt_time, o_sys_time;

  qpu_exu_evt_sched_if #(.TIME_W(TW), .EDATA_W(EW), .OPR_W(OW)) wb ();

  qpu_exu_evt_sched #(.TIME_W(TW), .EDATA_W(EW), .OPR_W(OW), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .wb           (wb),
    .o_evt_valid  (o_evt_valid),
    .o_evt_data   (o_evt_data),
    .o_evt_oprand (o_evt_oprand),
    .o_evt_time   (o_evt_time),
    .o_sys_time   (o_sys_time),
    .o_late       (o_late),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // Reference model
  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mst_t;
  typedef struct {
    int unsigned ts;
    int unsigned data;
    int unsigned opr;
  } ent_t;

  mst_t        ms;
  int unsigned msys, mtl;
  ent_t        mq[$];
  bit          mlate, mvalid;
  ent_t        mevt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (ms != M_DRAIN) && (mq.size() < DP);
  endfunction

  task automatic model_reset();
    ms = M_IDLE; msys = 0; mtl = 0; mq.delete();
    mlate = 0; mvalid = 0; mevt = '{0, 0, 0};
  endtask

  task automatic check_outputs();
    chk("t_ready", {31'd0, wb.twbck_i_ready}, {31'd0, m_ready()});
    chk("e_ready", {31'd0, wb.ewbck_i_ready}, {31'd0, m_ready()});
    chk("busy", {31'd0, o_busy}, {31'd0, (ms != M_IDLE) || (mq.size() != 0)});
    chk("sys_time", {24'd0, o_sys_time}, msys);
    chk("late", {31'd0, o_late}, {31'd0, mlate});
    chk("evt_valid", {31'd0, o_evt_valid}, {31'd0, mvalid});
    if (mvalid) begin
      chk("evt_time", {24'd0, o_evt_time}, mevt.ts);
      chk("evt_data", {24'd0, o_evt_data}, mevt.data);
      chk("evt_opr", {28'd0, o_evt_oprand}, mevt.opr);
    end
  endtask

  task automatic model_step(input bit st, sp, tv, input int unsigned td,
                            input bit ev, input int unsigned ed, eo,
                            output bit fired);
    bit          rdy, tf, ef, was_empty;
    int unsigned ntl, d;
    rdy = m_ready();
    tf  = tv && rdy;
    ef  = ev && rdy;
    ntl = (mtl + (tf ? td : 0)) & MASK;
    was_empty = (mq.size() == 0);
    mvalid = 0;
    if (ms != M_IDLE && mq.size() != 0) begin
      d = (mq[0].ts + (1 << TW) - msys) & MASK;
      if (d == 0 || d >= HALF) begin
        mevt   = mq.pop_front();
        mvalid = 1;
        if (d != 0) mlate = 1;
      end
    end
    if (ef && eo != 0) mq.push_back('{ntl, ed, eo});
    fired = ef;
    case (ms)
      M_IDLE:  begin msys = 0; mtl = ntl; if (st) ms = M_RUN; end
      M_RUN:   begin msys = (msys + 1) & MASK; mtl = ntl; if (sp) ms = M_DRAIN; end
      default: begin
        if (was_empty) begin ms = M_IDLE; msys = 0; mtl = 0; end
        else msys = (msys + 1) & MASK;
      end
    endcase
  endtask

  // One clock cycle: drive, check at negedge, advance model, resume after posedge.
  task automatic cyc(input bit st, sp, tv, input int unsigned td,
                     input bit ev, input int unsigned ed, eo, output bit fired);
    i_start = st; i_stop = sp;
    wb.twbck_i_valid = tv; wb.twbck_i_data = td[TW-1:0];
    wb.ewbck_i_valid = ev; wb.ewbck_i_data = ed[EW-1:0];
    wb.ewbck_i_oprand = eo[OW-1:0];
    @(negedge clk);
    check_outputs();
    model_step(st, sp, tv, td, ev, ed, eo, fired);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit f;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, f);
  endtask

  task automatic wait_sys(input int unsigned t);
    int k = 0;
    while (msys != t && k < 600) begin idle(1); k++; end
    if (k >= 600) chk("wait_sys_timeout", 1, 0);
  endtask

  task automatic stop_and_drain();
    bit f;
    int k = 0;
    cyc(0, 1, 0, 0, 0, 0, 0, f);
    while (ms != M_IDLE && k < 600) begin idle(1); k++; end
    if (k >= 600) chk("drain_timeout", 1, 0);
    idle(2);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_evt_valid", {31'd0, o_evt_valid}, 0);
    chk("rst_evt_time", {24'd0, o_evt_time}, 0);
    chk("rst_evt_data", {24'd0, o_evt_data}, 0);
    chk("rst_evt_opr", {28'd0, o_evt_oprand}, 0);
    chk("rst_sys_time", {24'd0, o_sys_time}, 0);
    chk("rst_late", {31'd0, o_late}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit f;
    int sent;
    rst = 1'b1;
    i_start = 0; i_stop = 0;
    wb.twbck_i_valid = 0; wb.twbck_i_data = '0;
    wb.ewbck_i_valid = 0; wb.ewbck_i_data = '0; wb.ewbck_i_oprand = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // IDLE preload: A at stamp 0, wait 10, B at stamp 10
    cyc(0, 0, 0, 0, 1, 8'hA1, 4'h1, f);
    cyc(0, 0, 1, 10, 0, 0, 0, f);
    cyc(0, 0, 0, 0, 1, 8'hB2, 4'h2, f);
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    idle(15);
    stop_and_drain();

    // Joint QWAIT beat with empty operand: timeline moves, nothing queued
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    cyc(0, 0, 1, 5, 1, 8'h33, 4'h0, f);
    cyc(0, 0, 0, 0, 1, 8'h34, 4'h8, f);
    idle(10);
    stop_and_drain();

    // Full: nine events at stamp 100, ninth stalls until the first pop
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    cyc(0, 0, 1, 100, 0, 0, 0, f);
    sent = 0;
    for (int k = 0; k < 200 && sent < DP + 1; k++) begin
      cyc(0, 0, 0, 0, 1, 8'h40 + sent, 4'h1 + sent[3:0], f);
      if (f) sent++;
    end
    chk("full_all_sent", sent, DP + 1);
    idle(5);
    stop_and_drain();

    // Late: stamp 20 pushed at sys_time 50
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    wait_sys(50);
    cyc(0, 0, 1, 20, 1, 8'h55, 4'h4, f);
    idle(6);
    stop_and_drain();

    // Wrap: timeline 250+10 -> stamp 4, released after the timer wraps
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    cyc(0, 0, 1, 250, 0, 0, 0, f);
    wait_sys(250);
    cyc(0, 0, 1, 10, 1, 8'h66, 4'h6, f);
    wait_sys(6);
    stop_and_drain();

    // Stop with two queued events, then reset in the middle of DRAIN
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    cyc(0, 0, 1, 30, 1, 8'h71, 4'h1, f);
    cyc(0, 0, 1, 3, 1, 8'h72, 4'h2, f);
    stop_and_drain();
    cyc(1, 0, 0, 0, 0, 0, 0, f);
    cyc(0, 0, 1, 40, 1, 8'h81, 4'h3, f);
    cyc(0, 0, 1, 2, 1, 8'h82, 4'h5, f);
    cyc(0, 1, 0, 0, 0, 0, 0, f);
    idle(3);
    do_reset();
    idle(3);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 6),
          $urandom_range(0, 1) == 1, $urandom_range(0, 255),
          $urandom_range(0, 15), f);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    if (ms == M_IDLE) cyc(1, 0, 0, 0, 0, 0, 0, f);
    stop_and_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
